bcd_display_scan: RTL and testbench

Two-digit multiplexed seven-segment driver that consumes the tens/units BCD digit pair from the binary-to-BCD converter and drives one shared segment bus plus two digit enables. It latches a digit pair on a load strobe and applies it only at frame boundaries, so a frame never mixes old and new digits. Each digit is shown in turn, with a blanking gap between digits to prevent ghosting. Optional leading-zero suppression and a dash glyph for invalid BCD codes are provided.

---
 rtl/bcd_display_scan.sv | 210 +++++++++++++++++++++
 tb/tb_bcd_display_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment scanner with frame-aligned digit updates,
// inter-digit blanking, optional leading-zero suppression and a dash for non-BCD codes.
module bcd_display_scan #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GAP_CYC        = 16,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] decenas,
    input  logic [3:0] unidades,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_start
);

    localparam int MAX_LEN = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
    localparam int CW      = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] LAST_LIT = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LAST_GAP = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [6:0] GLYPH_OFF  = 7'h00;
    localparam logic [6:0] GLYPH_DASH = 7'h40;
    localparam logic [6:0] GLYPH_ZERO = 7'h3F;

    typedef enum logic [1:0] {
        ST_UNITS = 2'd0,
        ST_GAP_A = 2'd1,
        ST_TENS  = 2'd2,
        ST_GAP_B = 2'd3
    } state_t;

    // Active-high {g..a} pattern for one BCD code; non-decimal codes show a dash.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] apply_polarity(input logic [6:0] g);
        logic [6:0] p;
        if (ACTIVE_LOW_SEG) begin
            p = ~g;
        end else begin
            p = g;
        end
        return p;
    endfunction

    state_t     state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s, phase_last_s;
    logic       wrap_s;

    logic [3:0] sh_t_r, sh_u_r, sh_t_nxt_s, sh_u_nxt_s;
    logic       sh_b_r, sh_b_nxt_s;
    logic [3:0] d_t_r, d_u_r, d_t_nxt_s, d_u_nxt_s;
    logic       d_b_r, d_b_nxt_s;
    logic       pend_r, pend_nxt_s;

    logic [6:0] seg_r, seg_nxt_s;
    logic [1:0] dig_en_r, dig_en_nxt_s;
    logic       frame_start_r, frame_start_nxt_s;

    // Phase sequencing: count out the current phase, then step to the next one.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r + CNT_ONE;
        phase_last_s = LAST_GAP;
        case (state_r)
            ST_UNITS: phase_last_s = LAST_LIT;
            ST_TENS:  phase_last_s = LAST_LIT;
            default:  phase_last_s = LAST_GAP;
        endcase
        if (cnt_r == phase_last_s) begin
            cnt_nxt_s = CNT_ZERO;
            case (state_r)
                ST_UNITS: state_nxt_s = ST_GAP_A;
                ST_GAP_A: state_nxt_s = ST_TENS;
                ST_TENS:  state_nxt_s = ST_GAP_B;
                ST_GAP_B: state_nxt_s = ST_UNITS;
                default:  state_nxt_s = ST_UNITS;
            endcase
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    assign wrap_s = (state_r == ST_GAP_B) && (cnt_r == LAST_GAP);

    // Shadow capture and frame-boundary transfer; a load on the boundary edge goes straight through.
    always_comb begin
        sh_t_nxt_s = sh_t_r;
        sh_u_nxt_s = sh_u_r;
        sh_b_nxt_s = sh_b_r;
        d_t_nxt_s  = d_t_r;
        d_u_nxt_s  = d_u_r;
        d_b_nxt_s  = d_b_r;
        pend_nxt_s = pend_r;
        if (load) begin
            sh_t_nxt_s = decenas;
            sh_u_nxt_s = unidades;
            sh_b_nxt_s = blank_lz;
        end else begin
            sh_t_nxt_s = sh_t_r;
            sh_u_nxt_s = sh_u_r;
            sh_b_nxt_s = sh_b_r;
        end
        if (wrap_s && load) begin
            d_t_nxt_s  = decenas;
            d_u_nxt_s  = unidades;
            d_b_nxt_s  = blank_lz;
            pend_nxt_s = 1'b0;
        end else if (wrap_s && pend_r) begin
            d_t_nxt_s  = sh_t_r;
            d_u_nxt_s  = sh_u_r;
            d_b_nxt_s  = sh_b_r;
            pend_nxt_s = 1'b0;
        end else if (load) begin
            pend_nxt_s = 1'b1;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // Output decode from next-cycle state so the registered outputs track state with no lag.
    always_comb begin
        dig_en_nxt_s      = 2'b00;
        seg_nxt_s         = apply_polarity(GLYPH_OFF);
        frame_start_nxt_s = (state_nxt_s == ST_UNITS) && (cnt_nxt_s == CNT_ZERO);
        case (state_nxt_s)
            ST_UNITS: begin
                dig_en_nxt_s = 2'b01;
                seg_nxt_s    = apply_polarity(glyph(d_u_nxt_s));
            end
            ST_TENS: begin
                if (d_b_nxt_s && (d_t_nxt_s == 4'd0)) begin
                    dig_en_nxt_s = 2'b00;
                    seg_nxt_s    = apply_polarity(GLYPH_OFF);
                end else begin
                    dig_en_nxt_s = 2'b10;
                    seg_nxt_s    = apply_polarity(glyph(d_t_nxt_s));
                end
            end
            default: begin
                dig_en_nxt_s = 2'b00;
                seg_nxt_s    = apply_polarity(GLYPH_OFF);
            end
        endcase
    end

    // State, counter and load registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_UNITS;
            cnt_r   <= CNT_ZERO;
            sh_t_r  <= 4'd0;
            sh_u_r  <= 4'd0;
            sh_b_r  <= 1'b0;
            d_t_r   <= 4'd0;
            d_u_r   <= 4'd0;
            d_b_r   <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sh_t_r  <= sh_t_nxt_s;
            sh_u_r  <= sh_u_nxt_s;
            sh_b_r  <= sh_b_nxt_s;
            d_t_r   <= d_t_nxt_s;
            d_u_r   <= d_u_nxt_s;
            d_b_r   <= d_b_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    // Output registers; reset values match the decode of the reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_en_r      <= 2'b01;
            seg_r         <= apply_polarity(GLYPH_ZERO);
            frame_start_r <= 1'b1;
        end else begin
            dig_en_r      <= dig_en_nxt_s;
            seg_r         <= seg_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    assign seg         = seg_r;
    assign dig_en      = dig_en_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4, GAP_CYC=1 (10-cycle frame),
// driving an active-high and an active-low instance from the same stimulus.
module tb_bcd_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] decenas;
    logic [3:0] unidades;
    logic       blank_lz;
    logic [6:0] seg_h, seg_l;
    logic [1:0] dig_en_h, dig_en_l;
    logic       fs_h, fs_l;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;

    always #5 clk = ~clk;

    bcd_display_scan #(.REFRESH_DIV(4), .GAP_CYC(1), .ACTIVE_LOW_SEG(1'b0)) dut_h (
        .clk(clk), .rst(rst), .load(load), .decenas(decenas), .unidades(unidades),
        .blank_lz(blank_lz), .seg(seg_h), .dig_en(dig_en_h), .frame_start(fs_h)
    );

    bcd_display_scan #(.REFRESH_DIV(4), .GAP_CYC(1), .ACTIVE_LOW_SEG(1'b1)) dut_l (
        .clk(clk), .rst(rst), .load(load), .decenas(decenas), .unidades(unidades),
        .blank_lz(blank_lz), .seg(seg_l), .dig_en(dig_en_l), .frame_start(fs_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s pos=%0d: got %0h expected %0h at %0t", tag, pos, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected outputs at the current frame position for the shown digit pair.
    task automatic verify(input logic [3:0] t, input logic [3:0] u, input logic b);
        logic [1:0] e_dig;
        logic [6:0] e_seg;
        e_dig = 2'b00;
        e_seg = 7'h00;
        if (pos <= 3) begin
            e_dig = 2'b01;
            e_seg = ref_glyph(u);
        end else if (pos >= 5 && pos <= 8 && !(b && t == 4'd0)) begin
            e_dig = 2'b10;
            e_seg = ref_glyph(t);
        end
        check_eq("dig_en", {30'd0, dig_en_h}, {30'd0, e_dig});
        check_eq("dig_en_al", {30'd0, dig_en_l}, {30'd0, e_dig});
        check_eq("seg", {25'd0, seg_h}, {25'd0, e_seg});
        check_eq("seg_al", {25'd0, seg_l}, {25'd0, ~e_seg});
        check_eq("frame_start", {31'd0, fs_h}, {31'd0, (pos == 0)});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        pos = (pos + 1) % 10;
    endtask

    task automatic adv(input int n, input logic [3:0] t, input logic [3:0] u, input logic b);
        for (int i = 0; i < n; i++) begin
            tick();
            verify(t, u, b);
        end
    endtask

    task automatic load_tick(input logic [3:0] t, input logic [3:0] u, input logic b);
        decenas  = t;
        unidades = u;
        blank_lz = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        decenas  = 4'hF;
        unidades = 4'hF;
        blank_lz = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        decenas  = 4'd0;
        unidades = 4'd0;
        blank_lz = 1'b0;
        #3;
        verify(4'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pos = 0;

        // Free-running scan of the reset digits for two frames.
        verify(4'd0, 4'd0, 1'b0);
        adv(20, 4'd0, 4'd0, 1'b0);

        // Mid-frame load of 15 at the third UNITS cycle.
        adv(2, 4'd0, 4'd0, 1'b0);
        load_tick(4'd1, 4'd5, 1'b0);
        verify(4'd0, 4'd0, 1'b0);
        adv(6, 4'd0, 4'd0, 1'b0);
        adv(10, 4'd1, 4'd5, 1'b0);

        // Leading-zero suppression on and off, loaded on the boundary edge.
        load_tick(4'd0, 4'd7, 1'b1);
        verify(4'd0, 4'd7, 1'b1);
        adv(9, 4'd0, 4'd7, 1'b1);
        load_tick(4'd0, 4'd7, 1'b0);
        verify(4'd0, 4'd7, 1'b0);
        adv(9, 4'd0, 4'd7, 1'b0);

        // Two loads in one frame: only the later one is shown.
        adv(2, 4'd0, 4'd7, 1'b0);
        load_tick(4'd2, 4'd3, 1'b0);
        verify(4'd0, 4'd7, 1'b0);
        adv(2, 4'd0, 4'd7, 1'b0);
        load_tick(4'd4, 4'd8, 1'b0);
        verify(4'd0, 4'd7, 1'b0);
        adv(4, 4'd0, 4'd7, 1'b0);
        adv(10, 4'd4, 4'd8, 1'b0);

        // Non-BCD units code shows a dash.
        adv(3, 4'd4, 4'd8, 1'b0);
        load_tick(4'd4, 4'hC, 1'b0);
        verify(4'd4, 4'd8, 1'b0);
        adv(6, 4'd4, 4'd8, 1'b0);
        adv(10, 4'd4, 4'hC, 1'b0);

        // Load 99 on the GAP_B->UNITS edge: visible in the frame that starts there.
        load_tick(4'd9, 4'd9, 1'b0);
        verify(4'd9, 4'd9, 1'b0);
        adv(5, 4'd9, 4'd9, 1'b0);

        // Pending load then async reset during TENS: outputs snap back, pending load dropped.
        load_tick(4'd3, 4'd3, 1'b0);
        verify(4'd9, 4'd9, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        pos = 0;
        verify(4'd0, 4'd0, 1'b0);
        @(negedge clk);
        verify(4'd0, 4'd0, 1'b0);
        rst = 1'b0;
        adv(20, 4'd0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
